// File: rtl/mux_arb_pkg.sv
// Shared types and defaults for the round-robin output-mux arbiter.
// Combinational only: a state enum, default sizes and a lane-slice helper.
// No flow control here; users apply their own handshakes.
package mux_arb_pkg;

  localparam int NREQ_DEF     = 4;
  localparam int DW_DEF       = 8;
  localparam int MAX_HOLD_DEF = 8;
  localparam int SEL_W_DEF    = $clog2(NREQ_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

  // Extract lane idx from a packed bundle; a shift keeps the index width-agnostic.
  function automatic logic [DW_DEF-1:0] lane_slice(
    input logic [NREQ_DEF*DW_DEF-1:0] lanes,
    input logic [SEL_W_DEF-1:0]       idx
  );
    logic [NREQ_DEF*DW_DEF-1:0] w_shifted;
    w_shifted = lanes >> (int'(idx) * DW_DEF);
    return w_shifted[DW_DEF-1:0];
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Round-robin winner search: first set request at or above ptr, wrapping.
// Purely combinational, zero cycles.
// No backpressure; any_vld simply reports whether any request is set.
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int SEL_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic [SEL_W-1:0] o_winner,
  output logic             o_any_vld
);

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;

  // Rotate requests so bit 0 of w_rot corresponds to the pointer position.
  assign w_dbl     = {i_req, i_req} >> i_ptr;
  assign w_rot     = w_dbl[NREQ-1:0];
  assign o_any_vld = |i_req;

  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return SEL_W'(s);
  endfunction

  // Scan from the far end so the smallest rotated offset is the last to win.
  always_comb begin
    o_winner = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) o_winner = wrap_add(i_ptr, i);
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a registered output mux with bounded tenures.
// Grant 1 cycle after request; data/valid lag grant by 1; GRANT->GAP->IDLE turnaround.
// No downstream backpressure; ena low freezes all state and outputs.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_ena,
  input  logic [NREQ-1:0]          i_req,
  input  logic [NREQ-1:0]          i_last,
  input  logic [NREQ*DW-1:0]       i_lane_in,
  output logic [NREQ-1:0]          o_gnt,
  output logic [$clog2(NREQ)-1:0]  o_sel,
  output logic [DW-1:0]            o_data_out,
  output logic                     o_valid,
  output logic                     o_busy
);

  localparam int SEL_W  = $clog2(NREQ);
  localparam int HOLD_W = $clog2(MAX_HOLD);

  arb_state_e         r_state, w_state_nxt;
  logic [SEL_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [HOLD_W-1:0]  r_hold, w_hold_nxt;
  logic [NREQ-1:0]    r_gnt, w_gnt_nxt;
  logic [SEL_W-1:0]   r_sel, w_sel_nxt;
  logic [DW-1:0]      r_data, w_data_nxt;
  logic               r_valid, w_valid_nxt;

  logic [SEL_W-1:0]   w_winner;
  logic               w_any_vld;
  logic               w_exit;

  rr_pick #(
    .NREQ  (NREQ),
    .SEL_W (SEL_W)
  ) u_rr_pick (
    .i_req     (i_req),
    .i_ptr     (r_rr_ptr),
    .o_winner  (w_winner),
    .o_any_vld (w_any_vld)
  );

  // Only the owner's last/req matter; the hold cap forces preemption.
  assign w_exit = i_last[r_sel] | ~i_req[r_sel] | (r_hold == HOLD_W'(MAX_HOLD - 1));

  // Next-state and next-output decode; every target defaults to its current value.
  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_hold_nxt   = r_hold;
    w_gnt_nxt    = r_gnt;
    w_sel_nxt    = r_sel;
    w_data_nxt   = r_data;
    w_valid_nxt  = r_valid;
    case (r_state)
      ST_IDLE: begin
        w_gnt_nxt   = '0;
        w_valid_nxt = 1'b0;
        if (w_any_vld) begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = NREQ'(1) << w_winner;
          w_sel_nxt   = w_winner;
          w_hold_nxt  = '0;
        end
      end
      ST_GRANT: begin
        // The exit cycle still delivers a beat.
        w_data_nxt  = lane_slice(i_lane_in, r_sel);
        w_valid_nxt = 1'b1;
        if (w_exit) begin
          w_state_nxt  = ST_GAP;
          w_gnt_nxt    = '0;
          w_hold_nxt   = '0;
          w_rr_ptr_nxt = (r_sel == SEL_W'(NREQ - 1)) ? '0 : r_sel + SEL_W'(1);
        end else begin
          w_hold_nxt = r_hold + HOLD_W'(1);
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
        w_valid_nxt = 1'b0;
        w_data_nxt  = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers; reset overrides ena, ena low holds everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_hold   <= '0;
      r_gnt    <= '0;
      r_sel    <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
    end else if (i_ena) begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_hold   <= w_hold_nxt;
      r_gnt    <= w_gnt_nxt;
      r_sel    <= w_sel_nxt;
      r_data   <= w_data_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

  assign o_gnt      = r_gnt;
  assign o_sel      = r_sel;
  assign o_data_out = r_data;
  assign o_valid    = r_valid;
  assign o_busy     = (r_state != ST_IDLE);

endmodule
